aes_round_ctrl: RTL and testbench
=================================

# aes_round_ctrl

- Iterative AES-128 encryption engine controller.
- Accepts one plaintext/key pair through a valid/ready handshake and sequences ten rounds over a single shared round datapath: SubBytes, ShiftRows, the existing mixcolumns block, and AddRoundKey.
- Expands round keys on the fly and returns the ciphertext through a second valid/ready handshake.
- Sits between the AXI register/stream front end of the AES IP and the combinational round primitives.

## Interface
Parameters:
- None. AES-128 only: Nr = 10, fixed by package constant.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  plaintext/key pair presented.
- in_ready  out  1  block can accept a pair; high only in IDLE.
- pt  in  128  plaintext. Byte s0 = [127:120], s15 = [7:0]. Column-major: s0..s3 form column 0.
- key  in  128  cipher key, same byte order as pt.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  consumer accepts ciphertext.
- ct  out  128  ciphertext, same byte order as pt.
- busy  out  1  high in ROUND or DONE.
- round_idx  out  4  0 in IDLE; current round 1..10 in ROUND; 10 in DONE.
- abort  in  1  present only with AES_CTRL_ABORT_EN.

## Operation
States are IDLE, ROUND and DONE.

IDLE:
- in_ready = 1.
- On in_valid & in_ready:
  - state_reg <= pt ^ key.
  - rk_reg <= key.
  - rnd <= 1.
  - Go to ROUND.
- pt and key are sampled only on the accepting edge; they need not be held afterwards.

ROUND, one round per cycle:
- rk_next = key_step(rk_reg, RCON[rnd]).
- For rnd 1..9: state_reg <= mixcolumns(shiftrows(subbytes(state_reg))) ^ rk_next.
- For rnd 10: the MixColumns stage is bypassed.
- rk_reg <= rk_next.
- rnd increments by 1.
- After the rnd = 10 update, go to DONE.

DONE:
- out_valid = 1 and ct = state_reg.
- Both hold stable until out_ready.
- On out_valid & out_ready, go to IDLE.
- in_ready stays 0 in DONE, including the acceptance cycle itself; there is no same-cycle re-accept.

Reset and invariants:
- Reset mid-operation returns to IDLE and discards the block; no output is produced.
- rnd is 4 bits and never exceeds 10. Values 11..15 are illegal and force a return to IDLE.
- in_valid is ignored while not in IDLE.

## Timing
Reset values (asynchronous):
- Registers: fsm = IDLE, rnd = 0, state_reg = 0, rk_reg = 0.
- Outputs: in_ready = 1, out_valid = 0, busy = 0, ct = 0, round_idx = 0.

Latency and throughput:
- Accept edge at cycle 0; out_valid rises after edge 10, i.e. 10 cycles after acceptance.
- Minimum initiation interval is 12 cycles: accept, 10 rounds, DONE with out_ready = 1, then IDLE.

Combinational paths:
- None from inputs to outputs except abort (when compiled in) affecting next-state only.
- All outputs are registered or decoded from fsm/rnd.

Critical path:
- One round: sbox → shiftrows (wiring) → mixcolumns → XOR.
- Key step (sbox + XOR chain) runs in parallel.

## Configuration
AES_CTRL_ABORT_EN:
- Defined: adds the abort input. abort = 1 in ROUND or DONE forces IDLE on the next edge.
  - out_valid drops and no ciphertext is delivered.
  - state_reg and rk_reg are cleared to 0.
  - abort in IDLE has no effect; in_ready is unaffected.
  - Simultaneous abort and out_ready in DONE: abort wins and the transfer is not counted.
- Undefined: no abort port and no abort logic.

## Structure
Shared package aes_pkg holds:
- The fsm state enum {IDLE, ROUND, DONE}.
- NR = 10.
- The RCON[1:10] table: 01,02,04,08,10,20,40,80,1b,36.
- The 128-bit block typedef.
- The S-box function or table.

Sub-module aes_key_step (combinational), with ports rk_in[127:0], rcon[7:0] and rk_out[127:0]:
- w4 = w0 ^ SubWord(RotWord(w3)) ^ {rcon, 24'h0}.
- Each subsequent word = previous new word ^ the corresponding old word.

The existing mixcolumns block is instantiated once; subbytes and shiftrows are shared round primitives.

## Test plan
1. Reset then FIPS-197 App. B vector: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → ct 3925841d02dc09fbdc118597196a0b32, with out_valid exactly 10 cycles after acceptance.
2. FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → ct 69c4e0d86a7b0430d8cdb78070b4c55a; round_idx steps 1..10.
3. Backpressure: out_ready held 0 for 20 cycles → ct and out_valid stable, in_ready = 0. Then out_ready = 1 → IDLE next cycle, in_ready = 1.
4. Back-to-back: in_valid held high with vectors 1 then 2, out_ready = 1 → both ciphertexts correct, second acceptance exactly 12 cycles after the first.
5. rst pulsed at round 5 (not aligned to a clock edge) → outputs immediately at their reset values; the next vector 1 encrypts correctly.
6. With AES_CTRL_ABORT_EN: abort at round 3 → IDLE next edge, no out_valid pulse. A following vector 2 → 69c4e0d86a7b0430d8cdb78070b4c55a.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM states, round count, RCON, block type,
// S-box table and the SubBytes/ShiftRows/xtime round primitives.
package aes_pkg;

  localparam int unsigned NR    = 10;
  localparam int unsigned BLK_W = 128;
  localparam int unsigned RND_W = 4;

  typedef logic [BLK_W-1:0] block_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Forward S-box lookup.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  // Round constant for rounds 1..10; zero for anything else.
  function automatic logic [7:0] rcon_lut(input logic [RND_W-1:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes: S-box applied to every byte.
  function automatic block_t subbytes(input block_t s);
    block_t o;
    for (int i = 0; i < 16; i++) begin
      o[8*i +: 8] = sbox(s[8*i +: 8]);
    end
    return o;
  endfunction

  // ShiftRows: row r rotates left by r; byte (r,c) sits at index 4c+r, MSB first.
  function automatic block_t shiftrows(input block_t s);
    block_t o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(15-(4*c+r)) +: 8] = s[8*(15-(4*((c+r)%4)+r)) +: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: derives the next round key from the current one.
module aes_key_step
  import aes_pkg::sbox;
(
  input  logic [127:0] rk_in,
  input  logic [7:0]   rcon,
  output logic [127:0] rk_out
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w, sub_w;
  logic [31:0] w4, w5, w6, w7;

  assign w0 = rk_in[127:96];
  assign w1 = rk_in[95:64];
  assign w2 = rk_in[63:32];
  assign w3 = rk_in[31:0];

  assign rot_w = {w3[23:0], w3[31:24]};
  assign sub_w = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};

  // Word chain: each new word folds in the previous new word.
  assign w4 = w0 ^ sub_w ^ {rcon, 24'h0};
  assign w5 = w4 ^ w1;
  assign w6 = w5 ^ w2;
  assign w7 = w6 ^ w3;

  assign rk_out = {w4, w5, w6, w7};

endmodule

// File: rtl/aes_mixcolumns.sv
// MixColumns over the full 128-bit state, four independent columns.
module aes_mixcolumns
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  output logic [127:0] state_o
);

  // Per-column matrix multiply by {02,03,01,01} circulant.
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    state_o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = state_i[127-32*c -: 8];
      a1 = state_i[119-32*c -: 8];
      a2 = state_i[111-32*c -: 8];
      a3 = state_i[103-32*c -: 8];
      state_o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      state_o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      state_o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      state_o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption controller: one round per cycle over a shared
// datapath, on-the-fly key expansion, valid/ready on both sides.
// Optional build macro AES_CTRL_ABORT_EN adds an abort input that drops the
// block in flight from ROUND or DONE.
module aes_round_ctrl
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pt,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ct,
  output logic         busy,
`ifdef AES_CTRL_ABORT_EN
  input  logic         abort,
`endif
  output logic [3:0]   round_idx
);

  localparam logic [RND_W-1:0] LAST_RND = RND_W'(NR);

  fsm_e             fsm_q, fsm_d;
  block_t           state_q, state_d;
  block_t           rk_q, rk_d;
  logic [RND_W-1:0] rnd_q, rnd_d;

  block_t           sb_w, sr_w, mc_w, rk_next_w;
  logic             rnd_legal_w;

  // Shared round datapath: SubBytes -> ShiftRows -> MixColumns.
  assign sb_w = subbytes(state_q);
  assign sr_w = shiftrows(sb_w);

  aes_mixcolumns u_mixcolumns (
    .state_i (sr_w),
    .state_o (mc_w)
  );

  aes_key_step u_key_step (
    .rk_in  (rk_q),
    .rcon   (rcon_lut(rnd_q)),
    .rk_out (rk_next_w)
  );

  assign rnd_legal_w = (rnd_q >= RND_W'(1)) && (rnd_q <= LAST_RND);

  // State, key and round registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rk_q    <= '0;
      rnd_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rk_q    <= rk_d;
      rnd_q   <= rnd_d;
    end
  end

  // Next-state: accept, iterate ten rounds, hold result until taken.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rk_d    = rk_q;
    rnd_d   = rnd_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = pt ^ key;
          rk_d    = key;
          rnd_d   = RND_W'(1);
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        if (rnd_legal_w) begin
          // Final round skips MixColumns.
          state_d = ((rnd_q == LAST_RND) ? sr_w : mc_w) ^ rk_next_w;
          rk_d    = rk_next_w;
          if (rnd_q == LAST_RND) begin
            fsm_d = DONE;
          end else begin
            rnd_d = RND_W'(rnd_q + RND_W'(1));
          end
        end else begin
          fsm_d = IDLE;
          rnd_d = '0;
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_d = IDLE;
          rnd_d = '0;
        end
      end
      default: begin
        fsm_d = IDLE;
        rnd_d = '0;
      end
    endcase
`ifdef AES_CTRL_ABORT_EN
    // Abort overrides everything outside IDLE, including a DONE handoff.
    if (abort && (fsm_q != IDLE)) begin
      fsm_d   = IDLE;
      state_d = '0;
      rk_d    = '0;
      rnd_d   = '0;
    end
`endif
  end

  // Outputs decoded from the state register and round counter.
  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q == ROUND) || (fsm_q == DONE);
  assign round_idx = (fsm_q == IDLE) ? 4'd0 : rnd_q;
  assign ct        = (fsm_q == DONE) ? state_q : '0;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: FIPS-197 vectors, latency,
// backpressure, back-to-back, async reset, random blocks vs a reference model,
// and abort when built with AES_CTRL_ABORT_EN.
module tb_aes_round_ctrl;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] pt;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ct;
  logic         busy;
  logic [3:0]   round_idx;
`ifdef AES_CTRL_ABORT_EN
  logic         abort;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sb_tab [256];

  aes_round_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pt        (pt),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ct        (ct),
    .busy      (busy),
`ifdef AES_CTRL_ABORT_EN
    .abort     (abort),
`endif
    .round_idx (round_idx)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv, r1, r2, r3, r4;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      r1 = {inv[6:0], inv[7]};
      r2 = {r1[6:0], r1[7]};
      r3 = {r2[6:0], r2[7]};
      r4 = {r3[6:0], r3[7]};
      sb_tab[x] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] p, input logic [127:0] k);
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    logic [7:0]  a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8];
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb_tab[tmp[31:24]], sb_tab[tmp[23:16]], sb_tab[tmp[15:8]], sb_tab[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) begin
      tmp = w[i/4];
      s[i] = s[i] ^ tmp[31-8*(i%4) -: 8];
    end
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sb_tab[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          t[4*c+rr] = s[4*((c+rr)%4)+rr];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) begin
        tmp = w[4*r + i/4];
        s[i] = s[i] ^ tmp[31-8*(i%4) -: 8];
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a pair and hold it until the accepting edge has passed.
  task automatic do_accept(input logic [127:0] p, input logic [127:0] k, output bit to);
    int n;
    n = 0;
    in_valid = 1'b1; pt = p; key = k;
    while (!in_ready && n < 30) begin tick(); n++; end
    to = !in_ready;
    tick();
    in_valid = 1'b0;
    pt  = {$urandom, $urandom, $urandom, $urandom};
    key = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_out(output int cyc, output bit to);
    cyc = 0;
    while (!out_valid && cyc < 40) begin tick(); cyc++; end
    to = !out_valid;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; pt = '0; key = '0;
`ifdef AES_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    #12;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (ct !== 128'h0) begin n_fail++; $display("FAIL reset_ct: got %h want 0", ct); end
    n_tests++; if (round_idx !== 4'd0) begin n_fail++; $display("FAIL reset_round_idx: got %0d want 0", round_idx); end
    @(negedge clk); rst = 1'b0;
    tick();
    n_tests++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got in_ready=%b busy=%b want 1/0", in_ready, busy); end
  endtask

  task automatic test_vec_b();
    bit to; int cyc;
    do_accept(PT_B, KEY_B, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL vecb_accept: got timeout want accept"); end
    n_tests++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL vecb_busy: got busy=%b in_ready=%b want 1/0", busy, in_ready); end
    wait_out(cyc, to);
    n_tests++; if (cyc != 10) begin n_fail++; $display("FAIL vecb_latency: got %0d want 10", cyc); end
    n_tests++; if (ct !== CT_B) begin n_fail++; $display("FAIL vecb_ct: got %h want %h", ct, CT_B); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL vecb_release: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_vec_c();
    bit to;
    do_accept(PT_C, KEY_C, to);
    n_tests++; if (round_idx !== 4'd1 || to) begin n_fail++; $display("FAIL vecc_round_1: got %0d want 1", round_idx); end
    for (int k = 1; k <= 9; k++) begin
      tick();
      n_tests++; if (round_idx !== 4'(k + 1) || out_valid !== 1'b0) begin n_fail++; $display("FAIL vecc_round_step: got idx=%0d ov=%b want idx=%0d ov=0", round_idx, out_valid, k + 1); end
    end
    tick();
    n_tests++; if (out_valid !== 1'b1 || round_idx !== 4'd10) begin n_fail++; $display("FAIL vecc_done: got ov=%b idx=%0d want 1/10", out_valid, round_idx); end
    n_tests++; if (ct !== CT_C) begin n_fail++; $display("FAIL vecc_ct: got %h want %h", ct, CT_C); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit to; int cyc; int bad;
    do_accept(PT_B, KEY_B, to);
    wait_out(cyc, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL bp_wait: got timeout want out_valid"); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid !== 1'b1 || ct !== CT_B || in_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable cycles want 0 (ct=%h)", bad, ct); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_back_to_back();
    int cyc, acc, got;
    int acc_cyc [2];
    logic [127:0] got_ct [2];
    bit acc_now, xfer;
    logic [127:0] ctv;
    cyc = 0; acc = 0; got = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0;
    got_ct[0] = '0; got_ct[1] = '0;
    out_ready = 1'b1; in_valid = 1'b1; pt = PT_B; key = KEY_B;
    while (got < 2 && cyc < 80) begin
      acc_now = in_valid && in_ready;
      xfer = out_valid && out_ready;
      ctv = ct;
      tick(); cyc++;
      if (acc_now && acc < 2) begin
        acc_cyc[acc] = cyc; acc++;
        if (acc == 1) begin pt = PT_C; key = KEY_C; end
        else in_valid = 1'b0;
      end
      if (xfer) begin got_ct[got] = ctv; got++; end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_tests++; if (got != 2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", got); end
    n_tests++; if (got_ct[0] !== CT_B) begin n_fail++; $display("FAIL b2b_ct1: got %h want %h", got_ct[0], CT_B); end
    n_tests++; if (got_ct[1] !== CT_C) begin n_fail++; $display("FAIL b2b_ct2: got %h want %h", got_ct[1], CT_C); end
    n_tests++; if (acc_cyc[1] - acc_cyc[0] != 12) begin n_fail++; $display("FAIL b2b_interval: got %0d want 12", acc_cyc[1] - acc_cyc[0]); end
  endtask

  task automatic test_reset_mid();
    bit to; int cyc;
    do_accept(PT_B, KEY_B, to);
    for (int i = 0; i < 4; i++) tick();
    n_tests++; if (round_idx !== 4'd5) begin n_fail++; $display("FAIL rstmid_round: got %0d want 5", round_idx); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || ct !== 128'h0 || round_idx !== 4'd0) begin
      n_fail++; $display("FAIL rstmid_outputs: got ir=%b ov=%b busy=%b idx=%0d ct=%h want 1/0/0/0/0", in_ready, out_valid, busy, round_idx, ct);
    end
    @(negedge clk); rst = 1'b0;
    tick();
    do_accept(PT_B, KEY_B, to);
    wait_out(cyc, to);
    n_tests++; if (ct !== CT_B || cyc != 10) begin n_fail++; $display("FAIL rstmid_vec: got ct=%h lat=%0d want %h lat=10", ct, cyc, CT_B); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_random();
    bit to; int cyc; int dly;
    logic [127:0] p, k, exp_ct;
    for (int n = 0; n < 8; n++) begin
      p = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      exp_ct = aes_ref(p, k);
      do_accept(p, k, to);
      wait_out(cyc, to);
      n_tests++; if (ct !== exp_ct || cyc != 10) begin n_fail++; $display("FAIL rand_ct[%0d]: got %h lat=%0d want %h lat=10", n, ct, cyc, exp_ct); end
      dly = int'($urandom_range(0, 3));
      for (int i = 0; i < dly; i++) tick();
      n_tests++; if (ct !== exp_ct || out_valid !== 1'b1) begin n_fail++; $display("FAIL rand_hold[%0d]: got %h ov=%b want %h ov=1", n, ct, out_valid, exp_ct); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
    end
  endtask

`ifdef AES_CTRL_ABORT_EN
  task automatic test_abort();
    bit to; int cyc; int seen;
    do_accept(PT_B, KEY_B, to);
    tick(); tick();
    n_tests++; if (round_idx !== 4'd3) begin n_fail++; $display("FAIL abort_round: got %0d want 3", round_idx); end
    abort = 1'b1; tick(); abort = 1'b0;
    n_tests++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || round_idx !== 4'd0) begin
      n_fail++; $display("FAIL abort_idle: got ir=%b busy=%b ov=%b idx=%0d want 1/0/0/0", in_ready, busy, out_valid, round_idx);
    end
    seen = 0;
    for (int i = 0; i < 15; i++) begin tick(); if (out_valid) seen++; end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL abort_no_output: got %0d valid cycles want 0", seen); end
    abort = 1'b1;
    do_accept(PT_C, KEY_C, to);
    abort = 1'b0;
    n_tests++; if (busy !== 1'b1 || round_idx !== 4'd1) begin n_fail++; $display("FAIL abort_idle_noeffect: got busy=%b idx=%0d want 1/1", busy, round_idx); end
    wait_out(cyc, to);
    n_tests++; if (ct !== CT_C) begin n_fail++; $display("FAIL abort_vec2: got %h want %h", ct, CT_C); end
    abort = 1'b1; out_ready = 1'b1; tick(); abort = 1'b0; out_ready = 1'b0;
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_done: got ov=%b ir=%b want 0/1", out_valid, in_ready); end
  endtask
`endif

  initial begin
    build_sbox();
    test_reset();
    test_vec_b();
    test_vec_c();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef AES_CTRL_ABORT_EN
    test_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
